// File: rtl/alu_seq.sv
// Registered, handshaked ALU with persistent carry and variable-distance shifts.
// Optional ALU_SEQ_BARREL_EN: single-cycle barrel shifter instead of the iterative shift FSM.
module alu_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         zero,
  output logic         negative,
  output logic         carry,
  output logic         overflow,
  output logic         busy
);

  localparam int SHW = $clog2(W);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_SHL1 = 4'd5;
  localparam logic [3:0] OP_SHR1 = 4'd6;
  localparam logic [3:0] OP_PASS = 4'd7;
  localparam logic [3:0] OP_ADC  = 4'd8;
  localparam logic [3:0] OP_SBC  = 4'd9;
  localparam logic [3:0] OP_SHLN = 4'd10;
  localparam logic [3:0] OP_SHRN = 4'd11;
  localparam logic [3:0] OP_SARN = 4'd12;
  localparam logic [3:0] OP_ROL1 = 4'd13;
  localparam logic [3:0] OP_ROR1 = 4'd14;
  localparam logic [3:0] OP_CMP  = 4'd15;

  typedef enum logic {IDLE, SHIFT} state_e;

  typedef struct packed {
    logic [W-1:0] y;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
  } res_t;

  function automatic res_t flags_from(input logic [W-1:0] r, input logic c);
    res_t f;
    f.y = r;
    f.z = (r == '0);
    f.n = r[W-1];
    f.c = c;
    f.v = 1'b0;
    return f;
  endfunction

  // Shift kind: 0 = left, 1 = logical right, 2 = arithmetic right
  function automatic logic [1:0] kind_of(input logic [3:0] o);
    logic [3:0] t;
    t = o - OP_SHLN;
    return t[1:0];
  endfunction

`ifdef ALU_SEQ_BARREL_EN
  function automatic res_t shift_n(input logic [1:0] kind, input logic [W-1:0] v,
                                   input logic [SHW-1:0] n);
    logic signed [W-1:0] vs;
    logic [W-1:0]        r;
    logic                c;
    vs = v;
    c  = 1'b0;
    case (kind)
      2'd0:    r = v << n;
      2'd1:    r = v >> n;
      default: r = vs >>> n;
    endcase
    if (n != '0)
      c = (kind == 2'd0) ? v[W - int'(n)] : v[int'(n) - 1];
    return flags_from(r, c);
  endfunction
`else
  // Returns {bit shifted out, shifted word}
  function automatic logic [W:0] shift1(input logic [1:0] kind, input logic [W-1:0] v);
    case (kind)
      2'd0:    return {v[W-1], v[W-2:0], 1'b0};
      2'd1:    return {v[0], 1'b0, v[W-1:1]};
      default: return {v[0], v[W-1], v[W-1:1]};
    endcase
  endfunction
`endif

  function automatic res_t alu_eval(input logic [3:0] o, input logic [W-1:0] va,
                                    input logic [W-1:0] vb, input logic cin);
    res_t         r;
    logic [W:0]   s;
    logic [W-1:0] bx;
    logic [W-1:0] d;
    logic         cy;
    logic         ov_add;
    logic         ov_sub;
    bx = (o == OP_SUB || o == OP_SBC || o == OP_CMP) ? ~vb : vb;
    case (o)
      OP_ADC, OP_SBC: cy = cin;
      OP_SUB, OP_CMP: cy = 1'b1;
      default:        cy = 1'b0;
    endcase
    s      = {1'b0, va} + {1'b0, bx} + {{W{1'b0}}, cy};
    d      = s[W-1:0];
    ov_add = ~(va[W-1] ^ vb[W-1]) & (d[W-1] ^ va[W-1]);
    ov_sub = (va[W-1] ^ vb[W-1]) & (d[W-1] ^ va[W-1]);
    case (o)
      OP_AND:         r = flags_from(va & vb, 1'b0);
      OP_OR:          r = flags_from(va | vb, 1'b0);
      OP_XOR:         r = flags_from(va ^ vb, 1'b0);
      OP_ADD, OP_ADC: begin
        r   = flags_from(d, s[W]);
        r.v = ov_add;
      end
      OP_SUB, OP_SBC: begin
        r   = flags_from(d, s[W]);
        r.v = ov_sub;
      end
      OP_SHL1:        r = flags_from({va[W-2:0], 1'b0}, va[W-1]);
      OP_SHR1:        r = flags_from({1'b0, va[W-1:1]}, va[0]);
      OP_PASS:        r = flags_from(va, 1'b0);
`ifdef ALU_SEQ_BARREL_EN
      OP_SHLN, OP_SHRN, OP_SARN: r = shift_n(kind_of(o), va, vb[SHW-1:0]);
`else
      // Only the zero-distance case reaches here; N>0 goes through SHIFT
      OP_SHLN, OP_SHRN, OP_SARN: r = flags_from(va, 1'b0);
`endif
      OP_ROL1:        r = flags_from({va[W-2:0], va[W-1]}, va[W-1]);
      OP_ROR1:        r = flags_from({va[0], va[W-1:1]}, va[0]);
      default: begin
        // CMP: pass A through, flags describe A-B
        r   = flags_from(d, s[W]);
        r.y = va;
        r.v = ov_sub;
      end
    endcase
    return r;
  endfunction

  state_e state_p0, state_d;
  res_t   res_p1, ld_res, shift_res;
  logic   vld_p1;
  logic   ld, free, accept, is_iter, shift_done;

  assign free     = !vld_p1 || out_ready;
  assign in_ready = (state_p0 == IDLE) && free;
  assign accept   = in_valid && in_ready;
  assign busy     = (state_p0 == SHIFT);

`ifdef ALU_SEQ_BARREL_EN
  assign is_iter    = 1'b0;
  assign shift_done = 1'b0;
  assign shift_res  = '0;
`else
  logic [W-1:0]   work_p0;
  logic [SHW-1:0] cnt_p0;
  logic [1:0]     kind_p0;
  logic           sc_p0;
  logic [W:0]     step;

  assign is_iter = (op == OP_SHLN || op == OP_SHRN || op == OP_SARN) && (b[SHW-1:0] != '0);

  // The final bit is shifted combinationally into the load, so N shifts take N cycles
  always_comb begin
    step = {sc_p0, work_p0};
    if (cnt_p0 != '0)
      step = shift1(kind_p0, work_p0);
  end

  assign shift_done = (cnt_p0 <= SHW'(1));
  assign shift_res  = flags_from(step[W-1:0], step[W]);

  // Stage p0: iterative shift work register
  always_ff @(posedge clk) begin
    if (state_p0 == IDLE) begin
      if (accept) begin
        work_p0 <= a;
        cnt_p0  <= b[SHW-1:0];
        kind_p0 <= kind_of(op);
        sc_p0   <= 1'b0;
      end
    end else begin
      work_p0 <= step[W-1:0];
      sc_p0   <= step[W];
      if (cnt_p0 != '0)
        cnt_p0 <= cnt_p0 - SHW'(1);
    end
  end
`endif

  always_comb begin
    state_d = state_p0;
    ld      = 1'b0;
    ld_res  = '0;
    case (state_p0)
      IDLE: begin
        if (accept) begin
          if (is_iter) begin
            state_d = SHIFT;
          end else begin
            ld     = 1'b1;
            ld_res = alu_eval(op, a, b, res_p1.c);
          end
        end
      end
      SHIFT: begin
        if (shift_done && free) begin
          ld      = 1'b1;
          ld_res  = shift_res;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_p0 <= IDLE;
    else
      state_p0 <= state_d;
  end

  // Stage p1: result register; its carry bit is also the persistent C flag
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      res_p1 <= '0;
    end else if (ld) begin
      vld_p1 <= 1'b1;
      res_p1 <= ld_res;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign y         = res_p1.y;
  assign zero      = res_p1.z;
  assign negative  = res_p1.n;
  assign carry     = res_p1.c;
  assign overflow  = res_p1.v;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (W=8): directed vector table, hand sequences, and a random run
// checked cycle by cycle against a carry-tracking reference model and result queue.
module tb_alu_seq;

  typedef struct packed {
    logic [7:0] y;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
  } res_t;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    res_t       exp;
  } vec_t;

  logic       clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] op;
  logic [7:0] a, b, y;
  logic       zero, negative, carry, overflow, busy;

  res_t q[$];
  int   m_sh;
  logic m_ov, m_c;
  int   n_pass, n_tot;
  vec_t tab[22];

  alu_seq #(.W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .zero(zero), .negative(negative), .carry(carry), .overflow(overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic [3:0] o, input logic [7:0] va,
                                 input logic [7:0] vb, input logic cin);
    res_t       r;
    int         t, sr, cy, n;
    logic [7:0] w, d;
    r = '0; w = va; d = 8'h00; t = 0;
    cy = (o == 4'd8 || o == 4'd9) ? int'(cin) : 0;
    case (o)
      4'd0: w = va & vb;
      4'd1: w = va | vb;
      4'd2: w = va ^ vb;
      4'd3, 4'd8: begin
        t = int'(va) + int'(vb) + cy;
        w = t[7:0];
        r.c = (t > 255);
        sr = int'($signed(va)) + int'($signed(vb)) + cy;
        r.v = (sr > 127) || (sr < -128);
      end
      4'd4, 4'd9, 4'd15: begin
        if (o != 4'd9) cy = 1;
        t = int'(va) + 255 - int'(vb) + cy;
        d = t[7:0];
        r.c = (t > 255);
        sr = int'($signed(va)) - int'($signed(vb)) - 1 + cy;
        r.v = (sr > 127) || (sr < -128);
        w = (o == 4'd15) ? va : d;
      end
      4'd5: begin w = {va[6:0], 1'b0}; r.c = va[7]; end
      4'd6: begin w = {1'b0, va[7:1]}; r.c = va[0]; end
      4'd7: w = va;
      4'd10, 4'd11, 4'd12: begin
        n = int'(vb[2:0]);
        for (int i = 0; i < n; i++) begin
          if (o == 4'd10) begin r.c = w[7]; w = {w[6:0], 1'b0}; end
          else if (o == 4'd11) begin r.c = w[0]; w = {1'b0, w[7:1]}; end
          else begin r.c = w[0]; w = {w[7], w[7:1]}; end
        end
      end
      4'd13: begin w = {va[6:0], va[7]}; r.c = va[7]; end
      default: begin w = {va[0], va[7:1]}; r.c = va[0]; end
    endcase
    r.y = w;
    r.z = (o == 4'd15) ? (d == 8'h00) : (w == 8'h00);
    r.n = (o == 4'd15) ? d[7] : w[7];
    return r;
  endfunction

  function automatic vec_t mk(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb,
                              input logic [7:0] ey, input logic [3:0] znvc);
    vec_t v;
    v.op = o; v.a = va; v.b = vb;
    v.exp = {ey, znvc};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // One clock: drive inputs, compare outputs with the model, advance the model to the next edge
  task automatic cycle(input logic r, input logic iv, input logic [3:0] o, input logic [7:0] va,
                       input logic [7:0] vb, input logic ordy, input logic use_exp,
                       input res_t texp, output logic acc);
    res_t e;
    logic free, hs, rdy, ld;
    int   nsh;
    rst = r; in_valid = iv; op = o; a = va; b = vb; out_ready = ordy;
    #1;
    free = !m_ov || ordy;
    hs   = m_ov && ordy;
    rdy  = (m_sh == 0) && free;
    acc  = 1'b0;
    ld   = 1'b0;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("busy", 32'(busy), 32'(m_sh > 0));
    chk("in_ready", 32'(in_ready), 32'(rdy));
    if (m_ov) begin
      if (q.size() > 0) chk("result", 32'({y, zero, negative, carry, overflow}), 32'(q[0]));
      else chk("queue_empty", 32'(q.size()), 32'd1);
    end
    if (r) begin
      q.delete(); m_ov = 1'b0; m_sh = 0; m_c = 1'b0;
    end else begin
      if (hs) void'(q.pop_front());
      if (m_sh > 0) begin
        if (m_sh > 1) m_sh--;
        else if (free) begin m_sh = 0; ld = 1'b1; end
      end else if (iv && rdy) begin
        acc = 1'b1;
        e = use_exp ? texp : model(o, va, vb, m_c);
        m_c = e.c;
        q.push_back(e);
`ifdef ALU_SEQ_BARREL_EN
        nsh = 0;
`else
        nsh = (o >= 4'd10 && o <= 4'd12) ? int'(vb[2:0]) : 0;
`endif
        if (nsh > 0) m_sh = nsh;
        else ld = 1'b1;
      end
      if (ld) m_ov = 1'b1;
      else if (hs) m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb,
                       input logic ordy, input logic use_exp, input res_t texp);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) cycle(1'b0, 1'b1, o, va, vb, ordy, use_exp, texp, acc);
    if (!acc) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 4'd0, 8'h00, 8'h00, ordy, 1'b0, '0, acc);
  endtask

  initial begin
    logic       acc, pend;
    logic [3:0] ro;
    logic [7:0] ra, rb;
    int         got, cyc;
    n_pass = 0; n_tot = 0;
    m_sh = 0; m_ov = 1'b0; m_c = 1'b0;
    rst = 1'b1; in_valid = 1'b0; op = 4'd0; a = 8'h00; b = 8'h00; out_ready = 1'b0;

    tab[0]  = mk(4'd3,  8'hFF, 8'h01, 8'h00, 4'b1010);
    tab[1]  = mk(4'd8,  8'h00, 8'h00, 8'h01, 4'b0000);
    tab[2]  = mk(4'd4,  8'h80, 8'h01, 8'h7F, 4'b0011);
    tab[3]  = mk(4'd9,  8'h05, 8'h03, 8'h02, 4'b0010);
    tab[4]  = mk(4'd15, 8'h10, 8'h10, 8'h10, 4'b1010);
    tab[5]  = mk(4'd10, 8'h81, 8'h03, 8'h08, 4'b0000);
    tab[6]  = mk(4'd12, 8'h90, 8'h02, 8'hE4, 4'b0100);
    tab[7]  = mk(4'd11, 8'h5A, 8'h00, 8'h5A, 4'b0000);
    tab[8]  = mk(4'd0,  8'hF0, 8'h3C, 8'h30, 4'b0000);
    tab[9]  = mk(4'd1,  8'h0F, 8'h80, 8'h8F, 4'b0100);
    tab[10] = mk(4'd2,  8'hAA, 8'hAA, 8'h00, 4'b1000);
    tab[11] = mk(4'd5,  8'hC1, 8'h00, 8'h82, 4'b0110);
    tab[12] = mk(4'd6,  8'h03, 8'h00, 8'h01, 4'b0010);
    tab[13] = mk(4'd7,  8'h80, 8'h00, 8'h80, 4'b0100);
    tab[14] = mk(4'd13, 8'h81, 8'h00, 8'h03, 4'b0010);
    tab[15] = mk(4'd14, 8'h01, 8'h00, 8'h80, 4'b0110);
    tab[16] = mk(4'd11, 8'h81, 8'h08, 8'h81, 4'b0100);
    tab[17] = mk(4'd12, 8'h80, 8'h07, 8'hFF, 4'b0100);
    tab[18] = mk(4'd3,  8'h7F, 8'h01, 8'h80, 4'b0101);
    tab[19] = mk(4'd4,  8'h00, 8'h01, 8'hFF, 4'b0100);
    tab[20] = mk(4'd11, 8'hC0, 8'h07, 8'h01, 4'b0010);
    tab[21] = mk(4'd9,  8'h00, 8'h00, 8'h00, 4'b1010);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'({y, zero, negative, carry, overflow}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 22; i++) issue(tab[i].op, tab[i].a, tab[i].b, 1'b1, 1'b1, tab[i].exp);
    idle(3, 1'b1);

    // Backpressure: result held five cycles while a second op waits
    issue(4'd3, 8'h01, 8'h02, 1'b0, 1'b1, {8'h03, 4'b0000});
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 4'd2, 8'h0F, 8'hFF, 1'b0, 1'b1, {8'hF0, 4'b0100}, acc);
    issue(4'd2, 8'h0F, 8'hFF, 1'b1, 1'b1, {8'hF0, 4'b0100});
    idle(2, 1'b1);

    // Reset in the middle of a long shift, then ADC must see C=0
    issue(4'd11, 8'hFF, 8'h07, 1'b1, 1'b0, '0);
    idle(2, 1'b1);
    cycle(1'b1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 1'b0, '0, acc);
    chk("abort_result", 32'({y, zero, negative, carry, overflow}), 32'd0);
    issue(4'd8, 8'h01, 8'h01, 1'b1, 1'b1, {8'h02, 4'b0000});
    idle(2, 1'b1);

    got = 0; cyc = 0; pend = 1'b0; ro = 4'd0; ra = 8'h00; rb = 8'h00;
    while (got < 10000 && cyc < 80000) begin
      if (!pend) begin
        ro = 4'($urandom_range(0, 15));
        ra = 8'($urandom);
        rb = 8'($urandom);
        pend = 1'b1;
      end
      cycle(1'b0, 1'b1, ro, ra, rb, ($urandom_range(0, 3) != 0), 1'b0, '0, acc);
      if (acc) begin got++; pend = 1'b0; end
      cyc++;
    end
    chk("random_accepted", 32'(got), 32'd10000);
    idle(10, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
